// File: rtl/cmd_loader.sv
`default_nettype none
// ============================================================================
// Module   : cmd_loader
// Purpose  : Packs WORDS_PER_CMD host words into one command and writes it
//            to sequential command-memory addresses, one strobe per command.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_loader #(
   parameter int CMD_WIDTH      = 128,
   parameter int CMD_ADDR_WIDTH = 16,
   parameter int WORD_WIDTH     = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [CMD_ADDR_WIDTH-1:0] base_addr,
   input  logic [CMD_ADDR_WIDTH-1:0] num_cmds,
   input  logic [WORD_WIDTH-1:0]     word_in,
   input  logic                      word_valid,
   output logic                      word_ready,
   output logic [CMD_ADDR_WIDTH-1:0] cmd_write_addr,
   output logic [CMD_WIDTH-1:0]      cmd_write,
   output logic                      cmd_write_enable,
   output logic                      busy,
   output logic                      done
);

   localparam int WORDS_PER_CMD = CMD_WIDTH / WORD_WIDTH;
   localparam int IDX_W         = (WORDS_PER_CMD > 1) ? $clog2(WORDS_PER_CMD) : 1;
   localparam logic [IDX_W-1:0]          C_LAST_IDX = IDX_W'(WORDS_PER_CMD - 1);
   localparam logic [CMD_ADDR_WIDTH-1:0] C_ONE      = CMD_ADDR_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t                    r_state;
   state_t                    w_next_state;
   logic [CMD_ADDR_WIDTH-1:0] r_addr;
   logic [CMD_ADDR_WIDTH-1:0] r_remaining;
   logic [IDX_W-1:0]          r_word_idx;
   logic [CMD_WIDTH-1:0]      r_assembly;
   logic [CMD_WIDTH-1:0]      w_next_asm;
   logic                      w_handshake;
   logic                      w_last_word;
   logic                      w_last_cmd;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      word_ready   = (r_state == LOAD);
      w_handshake  = word_valid && word_ready;
      w_last_word  = (r_word_idx == C_LAST_IDX);
      w_last_cmd   = (r_remaining == C_ONE);
      case (r_state)
         IDLE: begin
            if (start && (num_cmds != '0)) begin
               w_next_state = LOAD;
            end
         end
         LOAD: begin
            if (w_handshake && w_last_word && w_last_cmd) begin
               w_next_state = FLUSH;
            end
         end
         FLUSH:   w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Assembly with the current word dropped into its slot, so the final
   // word can be written out in the same edge it is accepted.
   always_comb begin
      w_next_asm = r_assembly;
      for (int k = 0; k < WORDS_PER_CMD; k++) begin
         if (r_word_idx == IDX_W'(k)) begin
            w_next_asm[k*WORD_WIDTH +: WORD_WIDTH] = word_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr           <= '0;
         r_remaining      <= '0;
         r_word_idx       <= '0;
         r_assembly       <= '0;
         cmd_write        <= '0;
         cmd_write_addr   <= '0;
         cmd_write_enable <= 1'b0;
         done             <= 1'b0;
      end else begin
         cmd_write_enable <= 1'b0;
         done             <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  if (num_cmds != '0) begin
                     r_addr      <= base_addr;
                     r_remaining <= num_cmds;
                     r_word_idx  <= '0;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (w_handshake) begin
                  r_assembly <= w_next_asm;
                  if (w_last_word) begin
                     r_word_idx       <= '0;
                     cmd_write        <= w_next_asm;
                     cmd_write_addr   <= r_addr;
                     cmd_write_enable <= 1'b1;
                     r_addr           <= r_addr + C_ONE;
                     r_remaining      <= r_remaining - C_ONE;
                     done             <= w_last_cmd;
                  end else begin
                     r_word_idx <= r_word_idx + IDX_W'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy = (r_state != IDLE);

endmodule
`default_nettype wire
